// File: rtl/integ_pkg.sv
// Shared types and constants for the multi-axis inertial integrator.
// The state enum is exported on a debug port so checkers can follow the controller.
package integ_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [18:0] FUSION_INC  = 19'h03000;
  localparam int          SCALE_SHIFT = 5;

endpackage

// File: rtl/integ_axis.sv
// One rate channel: offset-compensate, scale, integrate with wrap or clamp,
// and capture the calibration offset from the running sum.
module integ_axis
  import integ_pkg::*;
#(
  parameter int RATE_W    = 16,
  parameter int CAL_SH    = 0,
  parameter int SCALE_NUM = 31,
  parameter int INT_W     = 27,
  parameter int OUT_W     = 12,
  parameter int SAT_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_run,
  input  logic                    i_vld_d1,
  input  logic                    i_acc_en,
  input  logic                    i_clr,
  input  logic                    i_sat_clr,
  input  logic                    i_cal_end,
  input  logic [RATE_W-1:0]       i_rate,
  input  logic signed [RATE_W+2:0] i_fuse,
  output logic [OUT_W-1:0]        o_heading,
  output logic                    o_sat
);

  localparam int CW = RATE_W + 3;
  localparam int PW = CW + 7;
  localparam int SW = INT_W + 2;
  localparam logic signed [SW-1:0] SUM_MAX = SW'({1'b0, {(INT_W-1){1'b1}}});
  localparam logic signed [SW-1:0] SUM_MIN = {3'b111, {(INT_W-1){1'b0}}};

  logic signed [CW-1:0]    r_comp;
  logic signed [CW-1:0]    r_scaled;
  logic signed [CW-1:0]    r_offset;
  logic signed [INT_W-1:0] r_integ;
  logic                    r_sat;

  logic signed [CW-1:0]    w_rate_sx;
  logic signed [CW-1:0]    w_rate_x8;
  logic signed [PW-1:0]    w_prod;
  logic signed [SW-1:0]    w_sum;
  logic                    w_ovf_hi;
  logic                    w_ovf_lo;
  logic signed [INT_W-1:0] w_next;
  logic signed [INT_W-1:0] w_cal_sum;

  assign w_rate_sx = CW'($signed(i_rate));
  assign w_rate_x8 = {i_rate, 3'b000};
  assign w_prod    = PW'(r_comp) * PW'(SCALE_NUM);

  // Three-term sum is two bits wider than the integrator so overflow is visible.
  assign w_sum    = SW'(r_integ) + SW'(r_scaled) + SW'(i_fuse);
  assign w_ovf_hi = (w_sum > SUM_MAX);
  assign w_ovf_lo = (w_sum < SUM_MIN);

  always_comb begin
    w_next = w_sum[INT_W-1:0];
    if (SAT_MODE != 0) begin
      if (w_ovf_hi)      w_next = {1'b0, {(INT_W-1){1'b1}}};
      else if (w_ovf_lo) w_next = {1'b1, {(INT_W-1){1'b0}}};
    end
  end

  // The last calibration sample is accumulated in the same cycle the offset
  // is captured, so the offset is taken from the post-accumulate value.
  assign w_cal_sum = i_acc_en ? w_next : r_integ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp   <= '0;
      r_scaled <= '0;
      r_offset <= '0;
      r_integ  <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_comp <= i_run ? (w_rate_x8 - r_offset) : w_rate_sx;
      if (i_vld_d1) r_scaled <= i_run ? CW'(w_prod >>> SCALE_SHIFT) : r_comp;
      if (i_clr)         r_integ <= '0;
      else if (i_acc_en) r_integ <= w_next;
      if (i_cal_end) r_offset <= CW'(w_cal_sum >>> CAL_SH);
      if (i_sat_clr)
        r_sat <= 1'b0;
      else if ((SAT_MODE != 0) && i_acc_en && (w_ovf_hi || w_ovf_lo))
        r_sat <= 1'b1;
    end
  end

  assign o_heading = r_integ[INT_W-1 -: OUT_W];
  assign o_sat     = r_sat;

endmodule

// File: rtl/inertial_integrator_ma.sv
// Gyro heading integrator: IDLE/CAL/RUN controller, calibration sample counter,
// vld pipeline and axis-0 guardrail fusion around NUM_AXES integ_axis channels.
module inertial_integrator_ma
  import integ_pkg::*;
#(
  parameter int NUM_AXES  = 3,
  parameter int RATE_W    = 16,
  parameter int CAL_LOG2  = 11,
  parameter int FAST_SIM  = 1,
  parameter int SCALE_NUM = 31,
  parameter int INT_W     = 27,
  parameter int OUT_W     = 12,
  parameter int SAT_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         strt_cal,
  input  logic                         vld,
  input  logic [NUM_AXES*RATE_W-1:0]   rate,
  input  logic                         lftIR,
  input  logic                         rghtIR,
  input  logic                         moving,
  input  logic                         clr_heading,
  output logic                         cal_done,
  output logic                         busy,
  output logic                         rdy,
  output logic [NUM_AXES*OUT_W-1:0]    heading,
  output logic [NUM_AXES-1:0]          sat,
  output state_t                       o_dbg_state
);

  // vld is a single-cycle strobe with no backpressure; rdy repeats it three
  // clocks later, in the cycle after the integrators absorbed that sample.
  localparam int CL    = (FAST_SIM != 0) ? 3 : CAL_LOG2;
  localparam int CNT_W = CL + 1;
  localparam int CW    = RATE_W + 3;
  localparam logic [CNT_W-1:0] CAL_N = {1'b1, {CL{1'b0}}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_vld_d1;
  logic                 r_vld_d2;
  logic                 r_rdy;
  logic                 w_cal_end;
  logic                 w_run;
  logic                 w_acc_en;
  logic                 w_clr;
  logic                 w_sat_clr;
  logic signed [CW-1:0] w_fuse0;
  logic [NUM_AXES-1:0]  w_sat;

  always_comb begin
    w_state_nxt = r_state;
    w_cal_end   = 1'b0;
    case (r_state)
      ST_IDLE: if (strt_cal) w_state_nxt = ST_CAL;
      ST_CAL: begin
        if (strt_cal) begin
          w_state_nxt = ST_CAL;
        end else if (r_cnt == CAL_N) begin
          w_state_nxt = ST_RUN;
          w_cal_end   = 1'b1;
        end
      end
      ST_RUN:  if (strt_cal) w_state_nxt = ST_CAL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_vld_d1 <= 1'b0;
      r_vld_d2 <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld_d1 <= vld;
      r_vld_d2 <= r_vld_d1;
      r_rdy    <= r_vld_d2;
      if (strt_cal)              r_cnt <= '0;
      else if (busy && r_vld_d1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign busy      = (r_state == ST_CAL);
  assign w_run     = (r_state == ST_RUN);
  assign cal_done  = w_cal_end;
  assign rdy       = r_rdy;
  assign w_acc_en  = r_vld_d2 & (busy | (w_run & moving));
  // Restart outranks clr_heading; both force the clear ahead of accumulation.
  assign w_clr     = strt_cal | w_cal_end | (w_run & clr_heading);
  assign w_sat_clr = strt_cal | (w_run & clr_heading);

  always_comb begin
    w_fuse0 = '0;
    if (w_run && lftIR && !rghtIR)      w_fuse0 = CW'(FUSION_INC);
    else if (w_run && rghtIR && !lftIR) w_fuse0 = -CW'(FUSION_INC);
  end

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    integ_axis #(
      .RATE_W    (RATE_W),
      .CAL_SH    (CL - 3),
      .SCALE_NUM (SCALE_NUM),
      .INT_W     (INT_W),
      .OUT_W     (OUT_W),
      .SAT_MODE  (SAT_MODE)
    ) u_axis (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (w_run),
      .i_vld_d1  (r_vld_d1),
      .i_acc_en  (w_acc_en),
      .i_clr     (w_clr),
      .i_sat_clr (w_sat_clr),
      .i_cal_end (w_cal_end),
      .i_rate    (rate[a*RATE_W +: RATE_W]),
      .i_fuse    ((a == 0) ? w_fuse0 : '0),
      .o_heading (heading[a*OUT_W +: OUT_W]),
      .o_sat     (w_sat[a])
    );
  end

  assign sat         = w_sat;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inertial_integrator_ma.sv
// Bench for inertial_integrator_ma: wrapping and saturating instances share one
// stimulus stream; results are checked against constants and a transaction model.
module tb_inertial_integrator_ma;
  import integ_pkg::*;

  localparam int NA = 3;
  localparam int RW = 16;
  localparam int OW = 12;
  localparam int M_IDLE = 0, M_CAL = 1, M_RUN = 2;
  localparam longint SMAX = (longint'(1) << 26) - 1;
  localparam longint SMIN = -(longint'(1) << 26);

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic strt_cal = 1'b0, vld = 1'b0, lftIR = 1'b0, rghtIR = 1'b0;
  logic moving = 1'b0, clr_heading = 1'b0;
  logic [NA*RW-1:0] rate = '0;
  logic cal_done_w, busy_w, rdy_w, cal_done_s, busy_s, rdy_s;
  logic [NA*OW-1:0] heading_w, heading_s;
  logic [NA-1:0] sat_w, sat_s;
  state_t st_w, st_s;

  always #5 clk = ~clk;

  inertial_integrator_ma #(.SAT_MODE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .rate(rate),
    .lftIR(lftIR), .rghtIR(rghtIR), .moving(moving), .clr_heading(clr_heading),
    .cal_done(cal_done_w), .busy(busy_w), .rdy(rdy_w), .heading(heading_w),
    .sat(sat_w), .o_dbg_state(st_w));

  inertial_integrator_ma #(.SAT_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .strt_cal(strt_cal), .vld(vld), .rate(rate),
    .lftIR(lftIR), .rghtIR(rghtIR), .moving(moving), .clr_heading(clr_heading),
    .cal_done(cal_done_s), .busy(busy_s), .rdy(rdy_s), .heading(heading_s),
    .sat(sat_s), .o_dbg_state(st_s));

  int n_checks = 0, n_pass = 0, cal_pulses = 0;
  always @(negedge clk) if (cal_done_w) cal_pulses++;

  // ---------------- reference model ----------------
  int     m_state = M_IDLE, m_cnt = 0;
  longint m_ofs[NA], m_sum[NA], m_iw[NA], m_is[NA];
  bit     m_sat[NA];

  function automatic longint wrapw(input longint v, input int w);
    longint m = longint'(1) << w;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint floor_div(input longint p, input longint d);
    longint q = p / d;
    if ((p % d != 0) && (p < 0)) q--;
    return q;
  endfunction

  function automatic longint heading_of(input longint i);
    return floor_div(i, 32768) & 64'hFFF;
  endfunction

  task automatic model_clear_ints();
    for (int a = 0; a < NA; a++) begin
      m_iw[a] = 0; m_is[a] = 0;
    end
  endtask

  task automatic model_vld(input logic [15:0] r0, r1, r2, input bit mv, l, rg);
    longint rr[NA];
    longint comp, sc, f, s;
    rr[0] = longint'($signed(r0)); rr[1] = longint'($signed(r1)); rr[2] = longint'($signed(r2));
    if (m_state == M_CAL) begin
      for (int a = 0; a < NA; a++) begin
        m_sum[a] += rr[a]; m_iw[a] = m_sum[a]; m_is[a] = m_sum[a];
      end
      m_cnt++;
      if (m_cnt == 8) begin
        for (int a = 0; a < NA; a++) m_ofs[a] = wrapw(floor_div(m_sum[a] * 8, 8), 19);
        model_clear_ints();
        m_state = M_RUN;
      end
    end else if (m_state == M_RUN && mv) begin
      for (int a = 0; a < NA; a++) begin
        comp = wrapw(rr[a] * 8 - m_ofs[a], 19);
        sc = wrapw(floor_div(comp * 31, 32), 19);
        f = 0;
        if (a == 0 && l && !rg) f = 12288;
        if (a == 0 && rg && !l) f = -12288;
        m_iw[a] = wrapw(m_iw[a] + sc + f, 27);
        s = m_is[a] + sc + f;
        if (s > SMAX) begin s = SMAX; m_sat[a] = 1'b1; end
        else if (s < SMIN) begin s = SMIN; m_sat[a] = 1'b1; end
        m_is[a] = s;
      end
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0;
    for (int a = 0; a < NA; a++) begin
      m_ofs[a] = 0; m_sum[a] = 0; m_sat[a] = 1'b0;
    end
    model_clear_ints();
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < NA; a++) begin
      chk($sformatf("%s_hw%0d", tag, a), longint'(heading_w[a*OW +: OW]), heading_of(m_iw[a]));
      chk($sformatf("%s_hs%0d", tag, a), longint'(heading_s[a*OW +: OW]), heading_of(m_is[a]));
      chk($sformatf("%s_sats%0d", tag, a), longint'(sat_s[a]), longint'(m_sat[a]));
      chk($sformatf("%s_satw%0d", tag, a), longint'(sat_w[a]), 0);
    end
    chk($sformatf("%s_busy", tag), longint'(busy_w), longint'(m_state == M_CAL));
  endtask

  task automatic chk_h(input string tag, input logic [11:0] e0, e1, e2);
    chk({tag, "_h0"}, longint'(heading_w[0 +: OW]), longint'(e0));
    chk({tag, "_h1"}, longint'(heading_w[OW +: OW]), longint'(e1));
    chk({tag, "_h2"}, longint'(heading_w[2*OW +: OW]), longint'(e2));
  endtask

  // ---------------- drivers (all entered and left at a negedge) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] r0, r1, r2, input bit mv, l, rg);
    rate = {r2, r1, r0}; moving = mv; lftIR = l; rghtIR = rg; vld = 1'b1;
    tick(); vld = 1'b0;
    tick(); chk("rdy_early", longint'(rdy_w), 0);
    tick(); chk("rdy_d3", longint'(rdy_w), 1);
    tick(); chk("rdy_width", longint'(rdy_w), 0);
    model_vld(r0, r1, r2, mv, l, rg);
  endtask

  task automatic start_cal();
    strt_cal = 1'b1; tick(); strt_cal = 1'b0;
    chk("busy_on_cal", longint'(busy_w), 1);
    m_state = M_CAL; m_cnt = 0;
    for (int a = 0; a < NA; a++) begin m_sum[a] = 0; m_sat[a] = 1'b0; end
    model_clear_ints();
  endtask

  task automatic clr();
    clr_heading = 1'b1; tick(); clr_heading = 1'b0;
    if (m_state == M_RUN) begin
      model_clear_ints();
      for (int a = 0; a < NA; a++) m_sat[a] = 1'b0;
    end
  endtask

  task automatic cal_with(input logic [15:0] r);
    start_cal();
    repeat (8) send(r, r, r, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hw"}, longint'(heading_w), 0);
    chk({tag, "_hs"}, longint'(heading_s), 0);
    chk({tag, "_busy"}, longint'(busy_w), 0);
    chk({tag, "_cal_done"}, longint'(cal_done_w), 0);
    chk({tag, "_rdy"}, longint'(rdy_w), 0);
    chk({tag, "_sat"}, longint'({sat_w, sat_s}), 0);
    chk({tag, "_state"}, longint'(st_w), longint'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] r0, r1, r2;
    bit          mv, l, rg;
    int          n;
    logic [11:0] e0, e1, e2;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int p0;
    logic [15:0] q0, q1, q2;
    tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 16, 12'h006, 12'h000, 12'h000};
    tbl[1] = '{16'h1000, 16'h2000, 16'hF000, 1, 0, 0, 4,  12'h003, 12'h007, 12'hFFC};
    tbl[2] = '{16'h1000, 16'h2000, 16'hF000, 0, 0, 0, 5,  12'h000, 12'h000, 12'h000};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 16, 12'hFFA, 12'h000, 12'h000};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 8,  12'h000, 12'h000, 12'h000};
    tbl[5] = '{16'h7FFF, 16'h0001, 16'hFFFF, 1, 0, 0, 1,  12'h007, 12'h000, 12'hFFF};
    tbl[6] = '{16'h8000, 16'h0000, 16'h0000, 1, 0, 0, 2,  12'hFF0, 12'h000, 12'h000};
    tbl[7] = '{16'h1000, 16'h0000, 16'h0000, 1, 1, 0, 2,  12'h002, 12'h000, 12'h000};
    model_reset();

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // vld in IDLE does nothing
    send(16'h1000, 16'h1000, 16'h1000, 1'b1, 1'b1, 1'b0);
    check_all("idle");

    // Calibration on 0x0010, then RUN with the same rate holds heading at 0
    p0 = cal_pulses;
    cal_with(16'h0010);
    tick();
    chk("cal_done_once", longint'(cal_pulses - p0), 1);
    chk("busy_fell", longint'(busy_w), 0);
    chk("state_run", longint'(st_w), longint'(ST_RUN));
    repeat (20) send(16'h0010, 16'h0010, 16'h0010, 1'b1, 1'b0, 1'b0);
    chk_h("cal10_run", 12'h000, 12'h000, 12'h000);
    check_all("cal10_run");

    // Offset precision; clr_heading must be ignored during CAL
    start_cal();
    repeat (4) send(16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0);
    clr();
    repeat (4) send(16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0, 1'b0);
    repeat (8) send(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk_h("ofs8000", 12'hFF8, 12'hFF8, 12'hFF8);
    check_all("ofs8000");

    // Table vectors with zero offset, each from cleared integrators
    cal_with(16'h0000);
    for (int v = 0; v < 8; v++) begin
      clr();
      repeat (tbl[v].n) send(tbl[v].r0, tbl[v].r1, tbl[v].r2, tbl[v].mv, tbl[v].l, tbl[v].rg);
      chk_h($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1, tbl[v].e2);
      check_all($sformatf("vec%0d", v));
    end

    // Fusion swap returns heading0 to zero
    clr();
    repeat (16) send(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk_h("fuse_l", 12'h006, 12'h000, 12'h000);
    repeat (16) send(16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk_h("fuse_swap", 12'h000, 12'h000, 12'h000);

    // Gating from a nonzero heading
    clr();
    repeat (4) send(16'h1000, 16'h2000, 16'hF000, 1'b1, 1'b0, 1'b0);
    repeat (20) send(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0);
    chk_h("gated", 12'h003, 12'h007, 12'hFFC);

    // strt_cal in RUN clears integrators on the next clock
    start_cal();
    chk_h("restart_clr", 12'h000, 12'h000, 12'h000);
    chk("restart_state", longint'(st_w), longint'(ST_CAL));
    repeat (8) send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // strt_cal beats clr_heading
    strt_cal = 1'b1; clr_heading = 1'b1; tick(); strt_cal = 1'b0; clr_heading = 1'b0;
    chk("both_busy", longint'(busy_w), 1);
    chk("both_state", longint'(st_w), longint'(ST_CAL));
    m_state = M_CAL; m_cnt = 0;
    for (int a = 0; a < NA; a++) m_sum[a] = 0;
    model_clear_ints();

    // Reset after four calibration samples
    repeat (4) send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    chk_h("cal_partial", 12'h003, 12'h003, 12'h003);
    rst_n = 1'b0;
    #2;
    chk_all_zero("midcal_rst");
    tick(); rst_n = 1'b1; tick();
    model_reset();
    check_all("post_rst");

    // Saturation vs wrap on a large constant rate
    cal_with(16'h0000);
    for (int i = 1; i <= 265; i++) begin
      send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
      if (i == 264) chk("sat_before", longint'(sat_s), 0);
    end
    chk("sat_set", longint'(sat_s), 7);
    chk("sat_heading", longint'(heading_s[0 +: OW]), 12'h7FF);
    chk("wrap_negative", longint'(heading_w[OW-1]), 1);
    chk("wrap_nosat", longint'(sat_w), 0);
    check_all("sat");
    clr();
    chk("sat_cleared", longint'(sat_s), 0);

    // Randomized calibration and run against the model
    start_cal();
    repeat (8) begin
      q0 = 16'($urandom_range(0, 65535));
      q1 = 16'($urandom_range(0, 65535));
      q2 = 16'($urandom_range(0, 65535));
      send(q0, q1, q2, 1'b0, 1'b0, 1'b0);
    end
    tick();
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) clr();
      q0 = 16'($urandom_range(0, 65535));
      q1 = 16'($urandom_range(0, 65535));
      q2 = 16'($urandom_range(0, 65535));
      send(q0, q1, q2, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      check_all($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inertial_integrator_ma.md
INERTIAL_INTEGRATOR_MA -- requirements
Module: inertial_integrator_ma

Interface
REQ-001 Parameter NUM_AXES, 3, number of gyro rate channels integrated in parallel.
REQ-002 Parameter RATE_W, 16, signed raw-rate width per axis.
REQ-003 Parameter CAL_LOG2, 11, log2 of calibration sample count; SHALL be >=3.
REQ-004 Parameter FAST_SIM, 1, nonzero overrides CAL_LOG2 with 3 (8 samples).
REQ-005 Parameter SCALE_NUM, 31, run-mode gain numerator over 32.
REQ-006 Parameter INT_W, 27, signed integrator width.
REQ-007 Parameter OUT_W, 12, signed heading width per axis.
REQ-008 Parameter SAT_MODE, 0, 0 = integrator wraps two's-complement, 1 = integrator saturates.
REQ-009 clk  input  1  system clock; the only clock in the block.
REQ-010 rst_n  input  1  reset; asynchronous, active-low.
REQ-011 strt_cal  input  1  starts or restarts calibration.
REQ-012 vld  input  1  one-cycle pulse; rate is valid.
REQ-013 rate  input  NUM_AXES*RATE_W  packed signed rates, axis 0 in LSBs.
REQ-014 lftIR, rghtIR  input  1 each  guardrail sensors, fused into axis 0 only.
REQ-015 moving  input  1  enables RUN-mode integration.
REQ-016 clr_heading  input  1  zeroes integrators in RUN; offsets kept.
REQ-017 cal_done  output  1  one-cycle pulse at calibration end.
REQ-018 busy  output  1  high while in CAL.
REQ-019 rdy  output  1  vld delayed exactly 3 clocks.
REQ-020 heading  output  NUM_AXES*OUT_W  per-axis heading = integrator[INT_W-1:INT_W-OUT_W].
REQ-021 sat  output  NUM_AXES  sticky per-axis saturation flag; always 0 when SAT_MODE=0.

Function
REQ-022 State machine states: IDLE, CAL, RUN. Transitions: IDLE->CAL on strt_cal; CAL->RUN when sample count = 2^CAL_LOG2; RUN->CAL on strt_cal; CAL->CAL restart on strt_cal.
REQ-023 Entry into CAL clears the sample counter and all integrators in the same cycle.
REQ-024 Stage 1, every clock: CAL: comp = sign-extended rate (RATE_W+3 bits). RUN: comp = {rate,3'b000} - offset.
REQ-025 Stage 2, on vld delayed 1: CAL: scaled = comp. RUN: scaled = (comp*SCALE_NUM) >>> 5, arithmetic, truncated to RATE_W+3 bits.
REQ-026 Stage 3, on vld delayed 2: CAL: integrator += sign-extended scaled. RUN: same, only when moving=1.
REQ-027 Axis-0 fusion, RUN only: lftIR&~rghtIR adds +0x03000; rghtIR&~lftIR adds -0x03000; both set or both clear add 0.
REQ-028 Sample counter increments on vld delayed 1 while in CAL.
REQ-029 Count reaching 2^CAL_LOG2 triggers four actions: cal_done=1 for one cycle; offset[a] <= integrator[a] >>> (CAL_LOG2-3), truncated to RATE_W+3 bits; all integrators cleared; next state RUN.
REQ-030 Clear priority: clear beats accumulate in the same cycle.
REQ-031 Input priority: strt_cal beats clr_heading; clr_heading is ignored outside RUN.
REQ-032 SAT_MODE=1: a sum exceeding INT_W signed range clamps to max or min and sets sat[a].
REQ-033 sat[a] clears only on strt_cal, clr_heading, or reset.
REQ-034 SAT_MODE=0: the integrator wraps modulo 2^INT_W, so heading wraps from +max to -min.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE; counter, integrators, offsets, pipeline vld flags, rdy, sat all 0; therefore cal_done=0, busy=0, heading=0.
REQ-036 Reset during CAL discards partial accumulation; offsets read 0 until the next completed calibration.

Structure
REQ-037 Package integ_pkg SHALL hold the state enum type, FUSION_INC (19'h03000) and the scale shift constant (5).
REQ-038 Per-axis datapath SHALL be sub-module integ_axis, holding the comp, scaled, integrator, offset and sat registers; NUM_AXES copies are instantiated via generate.
REQ-039 The top level SHALL hold the FSM, the sample counter, the vld pipeline and fusion selection.

Verification (defaults, FAST_SIM=1)
REQ-040 Calibration: strt_cal, then 8 vld with every axis rate=0x0010 -> cal_done pulses once, offset=0x80, busy falls. Then RUN, moving=1, rate=0x0010 -> heading stays 0.
REQ-041 Fusion: RUN, rates 0, lftIR=1, rghtIR=0, 16 vld while moving -> axis-0 integrator=0x30000, heading0=6, other axes 0. Swap the sensors -> heading0 returns toward 0.
REQ-042 Gating: RUN, moving=0, rate=0x0100 for 20 vld -> headings unchanged; rdy still pulses 3 clocks after each vld.
REQ-043 Saturation: SAT_MODE=1, offset 0, rate=0x7FFF, moving=1 -> sat=1 within 265 vld, heading=0x7FF. SAT_MODE=0 with the same stimulus -> heading goes negative, sat=0.
REQ-044 Boundaries: strt_cal in RUN -> integrators 0 next clock, busy=1. Assert rst_n low after 4 calibration vld -> all outputs 0. strt_cal and clr_heading in the same cycle -> CAL entered.
